sprite_mixer: RTL and testbench

//  Downstream of the player/alien/bullet/shield sprite drawers; consumes their per-pixel
//  *_on/*_color outputs, resolves layer priority with chroma-key transparency, and drives

---
 rtl/sprite_mixer_pkg.sv | 33 +++
 rtl/sprite_mixer_collision_reporter.sv | 56 +++++
 rtl/sprite_mixer.sv | 140 ++++++++++++++
 tb/tb_sprite_mixer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_mixer_pkg.sv
// Shared types and constants for the sprite mixer: pixel layout, layer
// priority order and collision flag bit positions.
package sprite_mixer_pkg;

   localparam int          COLOR_W_DEF     = 24;
   localparam logic [23:0] TRANSPARENT_DEF = 24'hFF00FF;
   localparam logic [23:0] BG_COLOR_DEF    = 24'h000000;

   localparam int NUM_LAYERS = 5;
   localparam int COLL_W     = 4;

   localparam int COLL_PB_ALIEN  = 0;
   localparam int COLL_PB_SHIELD = 1;
   localparam int COLL_AB_PLAYER = 2;
   localparam int COLL_AB_SHIELD = 3;

   typedef struct packed {
      logic [7:0] red;
      logic [7:0] green;
      logic [7:0] blue;
   } rgb_t;

   // Declaration order is draw priority: lower value wins
   typedef enum logic [2:0] {
      LAYER_PBULLET = 3'd0,
      LAYER_ABULLET = 3'd1,
      LAYER_PLAYER  = 3'd2,
      LAYER_ALIEN   = 3'd3,
      LAYER_SHIELD  = 3'd4,
      LAYER_BG      = 3'd5
   } layer_e;

endpackage

// File: rtl/sprite_mixer_collision_reporter.sv
// Accumulates per-pixel hit flags over a frame and offers one report per
// frame to game logic over valid/ready, merging reports the consumer missed.
module collision_reporter
   import sprite_mixer_pkg::*;
(
   input  logic              Clk,
   input  logic              Reset,
   input  logic [COLL_W-1:0] i_hit,
   input  logic              i_frameEnd,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [COLL_W-1:0] o_flags,
   output logic              o_overrun
);

   logic [COLL_W-1:0] r_accum;
   logic              r_valid;
   logic [COLL_W-1:0] r_flags;
   logic              r_overrun;
   logic              w_transfer;
   logic [COLL_W-1:0] w_report;

   assign w_transfer = r_valid && i_ready;
   assign w_report   = r_accum | i_hit;

   // A frame end landing on an accept edge starts a fresh report; otherwise it merges
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_accum   <= '0;
         r_valid   <= 1'b0;
         r_flags   <= '0;
         r_overrun <= 1'b0;
      end else if (i_frameEnd) begin
         r_accum <= '0;
         r_valid <= 1'b1;
         if (r_valid && !w_transfer) begin
            r_flags   <= r_flags | w_report;
            r_overrun <= 1'b1;
         end else begin
            r_flags   <= w_report;
            r_overrun <= 1'b0;
         end
      end else begin
         r_accum <= r_accum | i_hit;
         if (w_transfer) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
         end
      end
   end

   assign o_valid   = r_valid;
   assign o_flags   = r_flags;
   assign o_overrun = r_overrun;

endmodule

// File: rtl/sprite_mixer.sv
// Two-stage pixel mixer: registers sprite inputs, resolves layer priority with
// chroma-key transparency, and feeds per-pixel overlap hits to the reporter.
module sprite_mixer
   import sprite_mixer_pkg::*;
#(
   parameter int                 COLOR_W     = COLOR_W_DEF,
   parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_DEF,
   parameter logic [COLOR_W-1:0] BG_COLOR    = BG_COLOR_DEF,
   parameter int                 H_ACTIVE    = 640,
   parameter int                 V_ACTIVE    = 480
)(
   input  logic               Clk,
   input  logic               Reset,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic               video_en,
   input  logic               player_on,
   input  logic [COLOR_W-1:0] player_color,
   input  logic               alien_on,
   input  logic [COLOR_W-1:0] alien_color,
   input  logic               shield_on,
   input  logic [COLOR_W-1:0] shield_color,
   input  logic               pbullet_on,
   input  logic [COLOR_W-1:0] pbullet_color,
   input  logic               abullet_on,
   input  logic [COLOR_W-1:0] abullet_color,
   output logic [7:0]         Red,
   output logic [7:0]         Green,
   output logic [7:0]         Blue,
   output logic               coll_valid,
   input  logic               coll_ready,
   output logic [3:0]         coll_flags,
   output logic               coll_overrun
);

   localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
   localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

   logic                  r_video;
   logic [9:0]            r_drawX;
   logic [9:0]            r_drawY;
   logic [NUM_LAYERS-1:0] r_on;
   logic [COLOR_W-1:0]    r_color [NUM_LAYERS];
   rgb_t                  r_rgb;

   logic [NUM_LAYERS-1:0] w_opaque;
   layer_e                w_layer;
   logic [COLOR_W-1:0]    w_selColor;
   logic                  w_inArea;
   logic [COLL_W-1:0]     w_hit;
   logic                  w_frameEnd;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_video <= 1'b0;
         r_drawX <= '0;
         r_drawY <= '0;
         r_on    <= '0;
         for (int i = 0; i < NUM_LAYERS; i++) begin
            r_color[i] <= '0;
         end
      end else begin
         r_video                <= video_en;
         r_drawX                <= DrawX;
         r_drawY                <= DrawY;
         r_on[LAYER_PBULLET]    <= pbullet_on;
         r_on[LAYER_ABULLET]    <= abullet_on;
         r_on[LAYER_PLAYER]     <= player_on;
         r_on[LAYER_ALIEN]      <= alien_on;
         r_on[LAYER_SHIELD]     <= shield_on;
         r_color[LAYER_PBULLET] <= pbullet_color;
         r_color[LAYER_ABULLET] <= abullet_color;
         r_color[LAYER_PLAYER]  <= player_color;
         r_color[LAYER_ALIEN]   <= alien_color;
         r_color[LAYER_SHIELD]  <= shield_color;
      end
   end

   always_comb begin
      w_opaque = '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
         w_opaque[i] = r_on[i] && (r_color[i] != TRANSPARENT);
      end
   end

   // Scan from lowest priority upward so the highest-priority opaque layer wins
   always_comb begin
      w_layer = LAYER_BG;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (w_opaque[i]) begin
            w_layer = layer_e'(3'(i));
         end
      end
   end

   always_comb begin
      w_selColor = BG_COLOR;
      case (w_layer)
         LAYER_PBULLET: w_selColor = r_color[LAYER_PBULLET];
         LAYER_ABULLET: w_selColor = r_color[LAYER_ABULLET];
         LAYER_PLAYER:  w_selColor = r_color[LAYER_PLAYER];
         LAYER_ALIEN:   w_selColor = r_color[LAYER_ALIEN];
         LAYER_SHIELD:  w_selColor = r_color[LAYER_SHIELD];
         default:       w_selColor = BG_COLOR;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset || !r_video) begin
         r_rgb <= '0;
      end else begin
         r_rgb <= rgb_t'(w_selColor);
      end
   end

   assign w_inArea = r_video && (r_drawX <= X_LAST) && (r_drawY <= Y_LAST);

   assign w_hit[COLL_PB_ALIEN]  = w_inArea && w_opaque[LAYER_PBULLET] && w_opaque[LAYER_ALIEN];
   assign w_hit[COLL_PB_SHIELD] = w_inArea && w_opaque[LAYER_PBULLET] && w_opaque[LAYER_SHIELD];
   assign w_hit[COLL_AB_PLAYER] = w_inArea && w_opaque[LAYER_ABULLET] && w_opaque[LAYER_PLAYER];
   assign w_hit[COLL_AB_SHIELD] = w_inArea && w_opaque[LAYER_ABULLET] && w_opaque[LAYER_SHIELD];

   assign w_frameEnd = r_video && (r_drawX == X_LAST) && (r_drawY == Y_LAST);

   collision_reporter u_reporter (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_hit      (w_hit),
      .i_frameEnd (w_frameEnd),
      .i_ready    (coll_ready),
      .o_valid    (coll_valid),
      .o_flags    (coll_flags),
      .o_overrun  (coll_overrun)
   );

   assign Red   = r_rgb.red;
   assign Green = r_rgb.green;
   assign Blue  = r_rgb.blue;

endmodule

// File: tb/tb_sprite_mixer.sv
// Directed bench for sprite_mixer: streamed pixel table for the priority mux
// plus hand-written frame sequences for the collision report handshake.
module tb_sprite_mixer;

   logic        Clk;
   logic        Reset;
   logic [9:0]  DrawX, DrawY;
   logic        video_en;
   logic        player_on, alien_on, shield_on, pbullet_on, abullet_on;
   logic [23:0] player_color, alien_color, shield_color, pbullet_color, abullet_color;
   logic [7:0]  Red, Green, Blue;
   logic        coll_valid, coll_ready, coll_overrun;
   logic [3:0]  coll_flags;

   int nCompared   = 0;
   int nMismatched = 0;

   // on bits: {pbullet, abullet, player, alien, shield}
   typedef struct {
      logic        video;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [4:0]  on;
      logic [23:0] pbC, abC, plC, alC, shC;
   } pix_t;

   typedef struct {
      pix_t        px;
      logic [23:0] expRgb;
   } vec_t;

   vec_t vecs[$];

   sprite_mixer dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .DrawX         (DrawX),
      .DrawY         (DrawY),
      .video_en      (video_en),
      .player_on     (player_on),
      .player_color  (player_color),
      .alien_on      (alien_on),
      .alien_color   (alien_color),
      .shield_on     (shield_on),
      .shield_color  (shield_color),
      .pbullet_on    (pbullet_on),
      .pbullet_color (pbullet_color),
      .abullet_on    (abullet_on),
      .abullet_color (abullet_color),
      .Red           (Red),
      .Green         (Green),
      .Blue          (Blue),
      .coll_valid    (coll_valid),
      .coll_ready    (coll_ready),
      .coll_flags    (coll_flags),
      .coll_overrun  (coll_overrun)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic pix_t mkPix(input logic v, input logic [9:0] x, input logic [9:0] y,
                                  input logic [4:0] on, input logic [23:0] pb, input logic [23:0] ab,
                                  input logic [23:0] pl, input logic [23:0] al, input logic [23:0] sh);
      pix_t p;
      p.video = v; p.x = x; p.y = y; p.on = on;
      p.pbC = pb; p.abC = ab; p.plC = pl; p.alC = al; p.shC = sh;
      return p;
   endfunction

   localparam logic [23:0] OP = 24'h123456;
   localparam logic [23:0] TR = 24'hFF00FF;

   function automatic pix_t idlePix();
      return mkPix(1'b0, 10'd0, 10'd0, 5'b00000, OP, OP, OP, OP, OP);
   endfunction

   function automatic pix_t endPix();
      return mkPix(1'b1, 10'd639, 10'd479, 5'b00000, OP, OP, OP, OP, OP);
   endfunction

   task automatic addVec(input pix_t p, input logic [23:0] e);
      vec_t v;
      v.px = p;
      v.expRgb = e;
      vecs.push_back(v);
   endtask

   // Drives one pixel, then advances one clock and settles past the edge
   task automatic applyStimulus(input pix_t p);
      video_en      = p.video;
      DrawX         = p.x;
      DrawY         = p.y;
      pbullet_on    = p.on[4];
      abullet_on    = p.on[3];
      player_on     = p.on[2];
      alien_on      = p.on[1];
      shield_on     = p.on[0];
      pbullet_color = p.pbC;
      abullet_color = p.abC;
      player_color  = p.plC;
      alien_color   = p.alC;
      shield_color  = p.shC;
      @(posedge Clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkColl(input string name, input logic v, input logic [3:0] f, input logic o);
      checkOutput({name, ".valid"}, {31'd0, coll_valid}, {31'd0, v});
      checkOutput({name, ".flags"}, {28'd0, coll_flags}, {28'd0, f});
      checkOutput({name, ".overrun"}, {31'd0, coll_overrun}, {31'd0, o});
   endtask

   task automatic doReset();
      Reset = 1'b0;
      applyStimulus(idlePix());
      applyStimulus(idlePix());
      Reset = 1'b1;
   endtask

   initial begin
      Reset      = 1'b0;
      coll_ready = 1'b0;

      // Reset held with busy stimulus, including a colliding frame-end pixel
      for (int k = 0; k < 3; k++) begin
         coll_ready = k[0];
         applyStimulus(mkPix(1'b1, 10'd639, 10'd479, (k[0] ? 5'b11111 : 5'b10010),
                             24'hFFFFFF, 24'h00FF00, 24'h0000FF, 24'hFF0000, 24'h00FFFF));
         checkOutput("reset.rgb", {8'd0, Red, Green, Blue}, 32'd0);
         checkOutput("reset.valid", {31'd0, coll_valid}, 32'd0);
         checkOutput("reset.overrun", {31'd0, coll_overrun}, 32'd0);
      end
      coll_ready = 1'b0;
      Reset = 1'b1;

      addVec(mkPix(1'b1, 10'd100, 10'd200, 5'b00110, OP, OP, 24'h00FF00, 24'hFF0000, OP), 24'h00FF00);
      addVec(mkPix(1'b1, 10'd100, 10'd200, 5'b00110, OP, OP, TR, 24'hFF0000, OP), 24'hFF0000);
      addVec(mkPix(1'b0, 10'd100, 10'd200, 5'b10000, 24'hFFFFFF, OP, OP, OP, OP), 24'h000000);
      addVec(mkPix(1'b1, 10'd101, 10'd200, 5'b11111, 24'h112233, 24'h445566, 24'h778899,
                   24'hAABBCC, 24'hDDEEF0), 24'h112233);
      addVec(mkPix(1'b1, 10'd102, 10'd200, 5'b11111, TR, 24'h445566, 24'h778899,
                   24'hAABBCC, 24'hDDEEF0), 24'h445566);
      addVec(mkPix(1'b1, 10'd103, 10'd200, 5'b01111, 24'h112233, TR, 24'h778899,
                   24'hAABBCC, 24'hDDEEF0), 24'h778899);
      addVec(mkPix(1'b1, 10'd104, 10'd200, 5'b00001, OP, OP, OP, OP, 24'h0A0B0C), 24'h0A0B0C);
      addVec(mkPix(1'b1, 10'd105, 10'd200, 5'b00001, OP, OP, OP, 24'h654321, 24'h0A0B0C), 24'h0A0B0C);
      addVec(mkPix(1'b1, 10'd106, 10'd200, 5'b10000, TR, OP, OP, OP, OP), 24'h000000);
      addVec(mkPix(1'b1, 10'd107, 10'd200, 5'b00000, OP, OP, OP, OP, OP), 24'h000000);
      addVec(mkPix(1'b0, 10'd108, 10'd200, 5'b00100, OP, OP, 24'h778899, OP, OP), 24'h000000);
      addVec(mkPix(1'b1, 10'd109, 10'd200, 5'b00010, OP, OP, OP, 24'hAABBCC, OP), 24'hAABBCC);

      // Back-to-back pixels: each result must appear exactly two edges after its drive
      for (int i = 0; i <= vecs.size(); i++) begin
         applyStimulus((i < vecs.size()) ? vecs[i].px : idlePix());
         if (i >= 1) checkOutput($sformatf("mix[%0d]", i - 1), {8'd0, Red, Green, Blue},
                                 {8'd0, vecs[i - 1].expRgb});
      end

      // Blanked and off-screen overlaps never hit; an empty frame still reports
      doReset();
      applyStimulus(mkPix(1'b0, 10'd300, 10'd50, 5'b10010, OP, OP, OP, OP, OP));
      applyStimulus(mkPix(1'b1, 10'd700, 10'd50, 5'b10010, OP, OP, OP, OP, OP));
      applyStimulus(endPix());
      applyStimulus(idlePix());
      checkColl("emptyFrame", 1'b1, 4'b0000, 1'b0);
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      coll_ready = 1'b0;
      checkOutput("emptyFrame.accept", {31'd0, coll_valid}, 32'd0);

      // Single pbullet/alien overlap then accept
      applyStimulus(mkPix(1'b1, 10'd300, 10'd50, 5'b10010, OP, OP, OP, OP, OP));
      applyStimulus(endPix());
      checkOutput("basic.notEarly", {31'd0, coll_valid}, 32'd0);
      applyStimulus(idlePix());
      checkColl("basic", 1'b1, 4'b0001, 1'b0);
      applyStimulus(idlePix());
      checkColl("basic.hold", 1'b1, 4'b0001, 1'b0);
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      coll_ready = 1'b0;
      checkOutput("basic.accept", {31'd0, coll_valid}, 32'd0);

      // Missed report merges with the next frame and flags overrun
      applyStimulus(mkPix(1'b1, 10'd300, 10'd50, 5'b10010, OP, OP, OP, OP, OP));
      applyStimulus(endPix());
      applyStimulus(idlePix());
      checkColl("overrun.first", 1'b1, 4'b0001, 1'b0);
      applyStimulus(mkPix(1'b1, 10'd10, 10'd20, 5'b01100, OP, OP, OP, OP, OP));
      applyStimulus(endPix());
      applyStimulus(idlePix());
      checkColl("overrun.merged", 1'b1, 4'b0101, 1'b1);
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      coll_ready = 1'b0;
      checkColl("overrun.accept", 1'b0, 4'b0101, 1'b0);

      // Frame end coinciding with an accept replaces the report without overrun
      applyStimulus(mkPix(1'b1, 10'd5, 10'd5, 5'b10001, OP, OP, OP, OP, OP));
      applyStimulus(endPix());
      applyStimulus(idlePix());
      checkColl("replace.first", 1'b1, 4'b0010, 1'b0);
      applyStimulus(mkPix(1'b1, 10'd6, 10'd6, 5'b01001, OP, OP, OP, OP, OP));
      applyStimulus(endPix());
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      coll_ready = 1'b0;
      checkColl("replace.second", 1'b1, 4'b1000, 1'b0);
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      coll_ready = 1'b0;

      // Hit on the last pixel itself is part of that frame's report
      applyStimulus(mkPix(1'b1, 10'd639, 10'd479, 5'b10001, OP, OP, OP, OP, OP));
      applyStimulus(idlePix());
      checkColl("lastPixel", 1'b1, 4'b0010, 1'b0);
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      coll_ready = 1'b0;

      // Mid-frame reset throws away the partial accumulation
      applyStimulus(mkPix(1'b1, 10'd300, 10'd50, 5'b10010, OP, OP, OP, OP, OP));
      applyStimulus(idlePix());
      Reset = 1'b0;
      applyStimulus(idlePix());
      checkOutput("midReset.valid", {31'd0, coll_valid}, 32'd0);
      applyStimulus(idlePix());
      Reset = 1'b1;
      applyStimulus(endPix());
      applyStimulus(idlePix());
      checkColl("midReset.report", 1'b1, 4'b0000, 1'b0);
      coll_ready = 1'b1;
      applyStimulus(idlePix());
      checkOutput("midReset.accept", {31'd0, coll_valid}, 32'd0);

      // Ready held high while idle has no effect until a report exists
      applyStimulus(endPix());
      applyStimulus(idlePix());
      checkOutput("readyIdle.valid", {31'd0, coll_valid}, 32'd1);
      applyStimulus(idlePix());
      checkOutput("readyIdle.accept", {31'd0, coll_valid}, 32'd0);
      coll_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
